// File: rtl/servo_arbiter_pkg.sv
// rtl/servo_arbiter_pkg.sv - shared servo arbitration definitions
package servo_arbiter_pkg;

  localparam logic [7:0] DEFAULT_ANGLE = 8'd90;
  localparam logic [7:0] MAX_ANGLE     = 8'd180;

  localparam int REQ_EVENT1  = 0;
  localparam int REQ_EVENT2  = 1;
  localparam int REQ_PUZZLE2 = 2;
  localparam int NUM_REQ     = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  // Lowest index wins: event1 over event2 over the puzzle2 dial.
  function automatic logic [NUM_REQ-1:0] pick_highest(input logic [NUM_REQ-1:0] r);
    if (r[REQ_EVENT1])       return 3'b001;
    else if (r[REQ_EVENT2])  return 3'b010;
    else if (r[REQ_PUZZLE2]) return 3'b100;
    else                     return 3'b000;
  endfunction

endpackage

// File: rtl/servo_slew_limiter.sv
// rtl/servo_slew_limiter.sv - tick generator, target clamp and rate-limited angle
module servo_slew_limiter
  import servo_arbiter_pkg::*;
#(
  parameter int SLEW_DIV = 500000,
  parameter int STEP_DEG = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_en_i,
  input  logic [7:0] target_i,
  output logic [7:0] angle_o,
  output logic       settled_o
);

  localparam int CNT_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLEW_DIV - 1);
  localparam logic [7:0] STEP8 = 8'(STEP_DEG);
  localparam logic [8:0] STEP9 = 9'(STEP_DEG);

  logic [CNT_W-1:0] tick_cnt_q;
  logic [7:0]       angle_q;
  logic [7:0]       target_clamped;
  logic [8:0]       tgt9;
  logic [8:0]       ang9;
  logic [8:0]       dist9;
  logic             tick;
  logic [7:0]       angle_d;

  assign tick           = tick_en_i && (tick_cnt_q == CNT_LAST);
  assign target_clamped = (target_i > MAX_ANGLE) ? MAX_ANGLE : target_i;
  assign tgt9           = {1'b0, target_clamped};
  assign ang9           = {1'b0, angle_q};
  assign dist9          = (tgt9 >= ang9) ? (tgt9 - ang9) : (ang9 - tgt9);

  // Far from target: one full step; close enough: snap so we never overshoot.
  always_comb begin
    angle_d = angle_q;
    if (dist9 <= STEP9)    angle_d = target_clamped;
    else if (tgt9 > ang9)  angle_d = angle_q + STEP8;
    else                   angle_d = angle_q - STEP8;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_cnt_q <= '0;
      angle_q    <= DEFAULT_ANGLE;
    end else begin
      if (tick_en_i) begin
        if (tick_cnt_q == CNT_LAST) tick_cnt_q <= '0;
        else                        tick_cnt_q <= tick_cnt_q + CNT_W'(1);
      end
      if (tick) angle_q <= angle_d;
    end
  end

  assign angle_o   = angle_q;
  assign settled_o = (angle_q == target_clamped);

endmodule

// File: rtl/servo_arbiter.sv
// rtl/servo_arbiter.sv - priority servo ownership with minimum-hold preemption
module servo_arbiter
  import servo_arbiter_pkg::*;
#(
  parameter int SLEW_DIV = 500000,
  parameter int STEP_DEG = 2,
  parameter int MIN_HOLD = 5000000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [7:0]         angle0_i,
  input  logic [7:0]         angle1_i,
  input  logic [7:0]         angle2_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [7:0]         angle_out_o,
  output logic               settled_o
);

  localparam int HOLD_W = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [HOLD_W-1:0]  hold_q;
  logic               owner_active;
  logic [NUM_REQ-1:0] higher_req;
  logic [7:0]         target;

  assign owner_active = |(grant_q & req_i);
  // Bits below the one-hot owner are exactly the higher-priority requesters.
  assign higher_req   = req_i & (grant_q - 3'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_i) begin
            state_q <= ST_OWNED;
            grant_q <= pick_highest(req_i);
            hold_q  <= '0;
          end
        end
        ST_OWNED: begin
          if (!owner_active) begin
            if (|req_i) begin
              grant_q <= pick_highest(req_i);
            end else begin
              state_q <= ST_IDLE;
              grant_q <= '0;
            end
            hold_q <= '0;
          end else if ((|higher_req) && (hold_q == HOLD_MAX)) begin
            grant_q <= pick_highest(higher_req);
            hold_q  <= '0;
          end else if (hold_q != HOLD_MAX) begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    target = DEFAULT_ANGLE;
    if (grant_q[REQ_EVENT1])       target = angle0_i;
    else if (grant_q[REQ_EVENT2])  target = angle1_i;
    else if (grant_q[REQ_PUZZLE2]) target = angle2_i;
  end

  servo_slew_limiter #(
    .SLEW_DIV(SLEW_DIV),
    .STEP_DEG(STEP_DEG)
  ) u_slew (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .tick_en_i(1'b1),
    .target_i (target),
    .angle_o  (angle_out_o),
    .settled_o(settled_o)
  );

  assign grant_o = grant_q;

endmodule

// File: tb/tb_servo_arbiter.sv
// tb/tb_servo_arbiter.sv - scoreboard bench for servo_arbiter
module tb_servo_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [7:0] a0 = 8'd90;
  logic [7:0] a1 = 8'd90;
  logic [7:0] a2 = 8'd90;
  logic [2:0] grant_o;
  logic [7:0] angle_out_o;
  logic       settled_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] exp_g_q[$];
  logic [7:0] exp_a_q[$];

  servo_arbiter #(
    .SLEW_DIV(4),
    .STEP_DEG(2),
    .MIN_HOLD(8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .angle0_i   (a0),
    .angle1_i   (a1),
    .angle2_i   (a2),
    .grant_o    (grant_o),
    .angle_out_o(angle_out_o),
    .settled_o  (settled_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_angle(input logic [7:0] v, input int max_cyc, input string name);
    int n = 0;
    while (angle_out_o !== v && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, angle_out_o, v);
  endtask

  // Monitor: every observed change of grant/angle_out must match the next queued value
  initial begin
    logic [2:0] pg;
    logic [7:0] pa;
    logic [2:0] eg;
    logic [7:0] ea;
    pg = 3'b000;
    pa = 8'd90;
    forever begin
      @(negedge clk);
      if (grant_o !== pg) begin
        check("grant_onehot", ($countones(grant_o) <= 1), 1);
        if (exp_g_q.size() == 0) begin
          check("grant_unexpected_change", grant_o, pg);
        end else begin
          eg = exp_g_q.pop_front();
          check("grant_seq", grant_o, eg);
        end
        pg = grant_o;
      end
      if (angle_out_o !== pa) begin
        check("angle_range", (angle_out_o <= 8'd180), 1);
        if (exp_a_q.size() == 0) begin
          check("angle_unexpected_change", angle_out_o, pa);
        end else begin
          ea = exp_a_q.pop_front();
          check("angle_seq", angle_out_o, ea);
        end
        pa = angle_out_o;
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_grant", grant_o, 3'b000);
    check("rst_angle", angle_out_o, 8'd90);
    check("rst_settled", settled_o, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 10 == 9) begin
        check("idle_grant", grant_o, 3'b000);
        check("idle_angle", angle_out_o, 8'd90);
        check("idle_settled", settled_o, 1'b1);
      end
    end

    a2 = 8'd100;
    exp_g_q.push_back(3'b100);
    for (int v = 92; v <= 100; v += 2) exp_a_q.push_back(8'(v));
    req = 3'b100;
    #2;
    check("s2_grant_before_edge", grant_o, 3'b000);
    @(negedge clk);
    check("s2_grant_latency", grant_o, 3'b100);
    check("s2_not_settled", settled_o, 1'b0);
    wait_angle(8'd100, 60, "s2_reach_100");
    check("s2_settled", settled_o, 1'b1);

    exp_g_q.push_back(3'b000);
    for (int v = 98; v >= 90; v -= 2) exp_a_q.push_back(8'(v));
    req = 3'b000;
    wait_angle(8'd90, 60, "s2_back_to_90");
    check("s2_idle_grant", grant_o, 3'b000);

    a2 = 8'd90;
    a0 = 8'd30;
    exp_g_q.push_back(3'b100);
    exp_g_q.push_back(3'b001);
    for (int v = 88; v >= 30; v -= 2) exp_a_q.push_back(8'(v));
    req = 3'b100;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("s3_min_hold", grant_o, (c < 10) ? 3'b100 : 3'b001);
      if (c == 3) req = 3'b101;
    end
    wait_angle(8'd30, 200, "s3_reach_30");

    a1 = 8'd30;
    req = 3'b011;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("s4_no_low_preempt", grant_o, 3'b001);
    end
    exp_g_q.push_back(3'b010);
    req = 3'b010;
    @(negedge clk);
    check("s4_handoff", grant_o, 3'b010);

    for (int v = 32; v <= 180; v += 2) exp_a_q.push_back(8'(v));
    a1 = 8'd250;
    wait_angle(8'd180, 400, "s5_clamp_180");
    check("s5_settled", settled_o, 1'b1);
    repeat (8) begin
      @(negedge clk);
      check("s5_hold_180", angle_out_o, 8'd180);
    end

    for (int v = 178; v >= 150; v -= 2) exp_a_q.push_back(8'(v));
    a1 = 8'd100;
    wait_angle(8'd150, 100, "s6_reach_150");
    exp_a_q.push_back(8'd90);
    exp_g_q.push_back(3'b000);
    #2;
    rst = 1'b1;
    #1;
    check("s6_async_grant", grant_o, 3'b000);
    check("s6_async_angle", angle_out_o, 8'd90);
    check("s6_async_settled", settled_o, 1'b1);
    req = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("post_rst_grant", grant_o, 3'b000);
      check("post_rst_angle", angle_out_o, 8'd90);
    end

    check("grant_queue_drained", exp_g_q.size(), 0);
    check("angle_queue_drained", exp_a_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_arbiter.md
SERVO_ARBITER -- requirements
Module: servo_arbiter

Interface
REQ-001 Parameter SLEW_DIV, default 500000: clock cycles per slew tick (10 ms at 50 MHz); legal range 1 or more.
REQ-002 Parameter STEP_DEG, default 2: maximum angle change per slew tick, in degrees; legal range 1 to 90.
REQ-003 Parameter MIN_HOLD, default 5000000: minimum number of grant cycles before a higher-priority requester may preempt; legal range 0 or more.
REQ-004 clk  input  1: system clock, 50 MHz; the block uses one clock; all logic is on the rising edge.
REQ-005 rst  input  1: reset, asynchronous and active-high.
REQ-006 req  input  3: request vector; bit0 = event1 (highest priority), bit1 = event2, bit2 = puzzle2 dial (lowest priority).
REQ-007 angle0, angle1, angle2  input  8 each: requested angle in degrees for requesters 0, 1 and 2.
REQ-008 grant  output  3: one-hot registered grant, or all zeros when no requester owns the servo.
REQ-009 angle_out  output  8: slew-limited angle; this output drives the servo motor driver.
REQ-010 settled  output  1: high when angle_out equals the current target.

Function
REQ-011 The block has two states: IDLE and OWNED. In IDLE, grant = 000 and target = 90.
REQ-012 From IDLE, when any req bit is high, the block enters OWNED and grants the highest-priority active requester; grant asserts 1 cycle after req.
REQ-013 In OWNED, the owner keeps the grant while its req bit stays high. The hold counter increments every cycle and saturates at MIN_HOLD.
REQ-014 In OWNED, when the owner's req bit drops:
  - the grant moves on the next cycle to the highest-priority remaining active requester, and the hold counter clears;
  - if no requester is active, the block returns to IDLE.
REQ-015 In OWNED, a higher-priority request preempts the owner only once the hold counter equals MIN_HOLD. Before that point the request waits. A waiting request that deasserts is forgotten.
REQ-016 A lower-priority request never preempts the owner.
REQ-017 grant is one-hot or zero in every cycle. grant never switches directly between owners without the hold counter clearing.
REQ-018 If the owner drops its request and new requests arrive in the same cycle, REQ-014 applies to the set of requests active in that cycle.
REQ-019 Target = angle of the granted requester, re-sampled every cycle. Target values above 180 are clamped to 180.
REQ-020 The slew tick counter runs freely from 0 to SLEW_DIV-1 and emits one tick per wrap.
REQ-021 On each tick:
  - if |target - angle_out| is at most STEP_DEG, angle_out = target;
  - otherwise angle_out moves STEP_DEG toward target.
  The arithmetic uses 9 bits, so there is no wrap-around.
REQ-022 angle_out changes only on ticks and always stays within the range 0 to 180.
REQ-023 settled is combinational and equals (angle_out == target). A target change mid-slew takes effect at the next tick without restarting the tick counter.

Reset
REQ-024 While rst is high, the outputs are: grant = 000, angle_out = 90, settled = 1.
REQ-025 While rst is high, the state is IDLE, the hold counter is 0 and the tick counter is 0.
REQ-026 Reset asserted mid-slew or mid-grant takes effect immediately (asynchronously). Arbitration restarts from IDLE on the first clk edge after rst falls.

Structure
REQ-027 The shared game definitions include file holds the following localparams: DEFAULT_ANGLE = 90, MAX_ANGLE = 180, requester indices, and the IDLE/OWNED state encoding.
REQ-028 The slew logic (tick counter, clamp, step) is a sub-module named servo_slew_limiter. It has inputs target and tick enable, and outputs angle and settled.

Verification
REQ-029 All directed tests use SLEW_DIV = 4, STEP_DEG = 2 and MIN_HOLD = 8.
REQ-030 Scenario: reset, then no req for 100 cycles -> grant = 000, angle_out = 90, settled = 1 throughout.
REQ-031 Scenario: req = 100 with angle2 = 100 -> grant = 100 one cycle later; angle_out reads 92, 94, 96, 98, 100 on successive ticks; settled then rises.
REQ-032 Scenario: puzzle2 owns the grant, then req0 rises 3 cycles after the grant with angle0 = 30 -> grant stays 100 until the hold counter reaches 8, then becomes 001 on the next cycle; slew proceeds toward 30.
REQ-033 Scenario: event1 owns the grant and req1 rises -> grant never changes while req0 is high; req0 drops -> grant = 010 next cycle.
REQ-034 Scenario: angle1 = 250 while granted -> target is clamped to 180; angle_out never exceeds 180.
REQ-035 Scenario: rst pulsed while angle_out = 150 and slewing -> angle_out = 90 and grant = 000 immediately, without waiting for a clk edge.
